// File: rtl/sprite_compositor.sv
// Composites N_SPRITES square sprites over a background pixel stream.
// Sprite attributes are staged in shadow registers and committed on a vsync fall.
module sprite_compositor #(
    parameter int          N_SPRITES    = 4,
    parameter int          IDX_W        = 2,
    parameter int          SPRITE_W     = 16,
    parameter int          SPRITE_H     = 16,
    parameter int          BG_LATENCY   = 4,
    parameter int          ALPHA_M      = 2,
    parameter int          ALPHA_N_LOG2 = 2,
    parameter int          TOTAL_WIDTH  = 1024,
    parameter int          TOTAL_HEIGHT = 768,
    parameter logic [23:0] BLANK_COLOR  = 24'h000000
) (
    input  logic             vclock,
    input  logic             reset,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    input  logic [23:0]      bg_pixel,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [11:0]      wr_x,
    input  logic [11:0]      wr_y,
    input  logic [23:0]      wr_color,
    input  logic             wr_visible,
    input  logic             freeze,
    output logic             commit_done,
    output logic             phsync,
    output logic             pvsync,
    output logic             pblank,
    output logic [23:0]      pixel
);
    localparam int               EXTRA     = BG_LATENCY - 3;
    localparam int               BW        = 8 + ALPHA_N_LOG2 + 1;
    localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(N_SPRITES);
    localparam logic signed [12:0] HALF_W  = 13'(SPRITE_W / 2);
    localparam logic signed [12:0] HALF_H  = 13'(SPRITE_H / 2);

    typedef enum logic {ST_RUN = 1'b0, ST_COMMIT = 1'b1} state_t;

    state_t r_state;
    logic   r_vsync, r_pending, r_commit_done, r_wr_ready;
    logic   w_wr_valid, w_vs_fall;

    assign w_wr_valid  = wr_en && r_wr_ready && ({1'b0, wr_idx} < IDX_LIMIT);
    assign w_vs_fall   = r_vsync && !vsync;
    assign wr_ready    = r_wr_ready;
    assign commit_done = r_commit_done;

    // A write landing on the vsync-fall cycle is enough to trigger the commit.
    always_ff @(posedge vclock) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_vsync       <= 1'b1;
            r_pending     <= 1'b0;
            r_commit_done <= 1'b0;
            r_wr_ready    <= 1'b1;
        end else begin
            r_vsync <= vsync;
            case (r_state)
                ST_RUN: begin
                    if (w_wr_valid)
                        r_pending <= 1'b1;
                    if (w_vs_fall && (r_pending || w_wr_valid) && !freeze) begin
                        r_state       <= ST_COMMIT;
                        r_commit_done <= 1'b1;
                        r_wr_ready    <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_RUN;
                    r_pending     <= 1'b0;
                    r_commit_done <= 1'b0;
                    r_wr_ready    <= 1'b1;
                end
            endcase
        end
    end

    logic [11:0]        w_x, w_y;
    logic signed [12:0] w_xs, w_ys;
    assign w_x  = {1'b0, hcount} - 12'(TOTAL_WIDTH / 2);
    assign w_y  = 12'(TOTAL_HEIGHT) - {2'b00, vcount};
    assign w_xs = $signed({w_x[11], w_x});
    assign w_ys = $signed({w_y[11], w_y});

    logic [N_SPRITES-1:0]        w_hit, r_s1_hit;
    logic [N_SPRITES-1:0][23:0]  w_ac_color;

    genvar gi;
    generate
        for (gi = 0; gi < N_SPRITES; gi++) begin : g_spr
            localparam logic [IDX_W-1:0] SEL = IDX_W'(gi);
            logic [11:0]        r_sh_x, r_sh_y, r_ac_x, r_ac_y;
            logic [23:0]        r_sh_color, r_ac_color;
            logic               r_sh_vis, r_ac_vis;
            logic signed [12:0] w_cx, w_cy;

            always_ff @(posedge vclock) begin
                if (reset) begin
                    r_sh_vis <= 1'b0;
                    r_ac_vis <= 1'b0;
                end else begin
                    if (w_wr_valid && wr_idx == SEL) begin
                        r_sh_x     <= wr_x;
                        r_sh_y     <= wr_y;
                        r_sh_color <= wr_color;
                        r_sh_vis   <= wr_visible;
                    end
                    if (r_state == ST_COMMIT) begin
                        r_ac_x     <= r_sh_x;
                        r_ac_y     <= r_sh_y;
                        r_ac_color <= r_sh_color;
                        r_ac_vis   <= r_sh_vis;
                    end
                end
            end

            assign w_cx = $signed({r_ac_x[11], r_ac_x});
            assign w_cy = $signed({r_ac_y[11], r_ac_y});
            assign w_hit[gi] = r_ac_vis
                && (w_xs >= w_cx - HALF_W) && (w_xs < w_cx + HALF_W)
                && (w_ys >= w_cy - HALF_H) && (w_ys < w_cy + HALF_H);
            assign w_ac_color[gi] = r_ac_color;
        end
    endgenerate

    logic [23:0] w_top, w_sec;
    logic [1:0]  w_cnt;
    always_comb begin
        w_top = '0;
        w_sec = '0;
        w_cnt = 2'd0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (r_s1_hit[i]) begin
                if (w_cnt == 2'd0) begin
                    w_top = w_ac_color[i];
                    w_cnt = 2'd1;
                end else if (w_cnt == 2'd1) begin
                    w_sec = w_ac_color[i];
                    w_cnt = 2'd2;
                end
            end
        end
    end

    logic [23:0] r_s2_top, r_s2_sec, w_blend, r_s3_col;
    logic [1:0]  r_s2_cnt;
    logic        r_s3_hit;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [BW-1:0] w_sum;
            assign w_sum = BW'(r_s2_top[gi*8 +: 8]) * BW'(ALPHA_M)
                         + BW'(r_s2_sec[gi*8 +: 8]) * BW'((2 ** ALPHA_N_LOG2) - ALPHA_M);
            assign w_blend[gi*8 +: 8] = 8'(w_sum >> ALPHA_N_LOG2);
        end
    endgenerate

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_s1_hit <= '0;
            r_s2_top <= '0;
            r_s2_sec <= '0;
            r_s2_cnt <= 2'd0;
            r_s3_hit <= 1'b0;
            r_s3_col <= '0;
        end else begin
            r_s1_hit <= w_hit;
            r_s2_top <= w_top;
            r_s2_sec <= w_sec;
            r_s2_cnt <= w_cnt;
            r_s3_hit <= (r_s2_cnt != 2'd0);
            r_s3_col <= (r_s2_cnt == 2'd2) ? w_blend :
                        (r_s2_cnt == 2'd1) ? r_s2_top : 24'h000000;
        end
    end

    logic        w_al_hit;
    logic [23:0] w_al_col;
    generate
        if (EXTRA > 0) begin : g_dly
            logic [EXTRA-1:0] r_dh;
            logic [23:0]      r_dc [EXTRA];
            always_ff @(posedge vclock) begin
                if (reset) begin
                    r_dh <= '0;
                end else begin
                    r_dh[0] <= r_s3_hit;
                    r_dc[0] <= r_s3_col;
                    for (int k = 1; k < EXTRA; k++) begin
                        r_dh[k] <= r_dh[k-1];
                        r_dc[k] <= r_dc[k-1];
                    end
                end
            end
            assign w_al_hit = r_dh[EXTRA-1];
            assign w_al_col = r_dc[EXTRA-1];
        end else begin : g_nodly
            assign w_al_hit = r_s3_hit;
            assign w_al_col = r_s3_col;
        end
    endgenerate

    logic [BG_LATENCY-1:0] r_hs_dly, r_vs_dly, r_bl_dly;
    always_ff @(posedge vclock) begin
        if (reset) begin
            r_hs_dly <= '1;
            r_vs_dly <= '1;
            r_bl_dly <= '1;
        end else begin
            r_hs_dly <= {r_hs_dly[BG_LATENCY-2:0], hsync};
            r_vs_dly <= {r_vs_dly[BG_LATENCY-2:0], vsync};
            r_bl_dly <= {r_bl_dly[BG_LATENCY-2:0], blank};
        end
    end

    assign phsync = r_hs_dly[BG_LATENCY-1];
    assign pvsync = r_vs_dly[BG_LATENCY-1];
    assign pblank = r_bl_dly[BG_LATENCY-1];
    assign pixel  = pblank ? BLANK_COLOR : (w_al_hit ? w_al_col : bg_pixel);
endmodule
